// File: rtl/yarp_pkg.sv
// Shared types for the YARP memory arbiter: FSM states and port ownership.
package yarp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/yarp_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single memory port with one
// outstanding transaction and a bounded-starvation priority for the data side.
module yarp_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_gnt_o,
  output logic        imem_rvalid_o,
  output logic [31:0] imem_rdata_o,

  input  logic        dmem_req_i,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_wr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_be_i,
  output logic        dmem_gnt_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,

  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e       state_q;
  owner_e           owner_q;
  logic [CNT_W-1:0] starve_q;
  logic [31:0]      addr_q;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  logic             pick_dmem;
  logic [CNT_W-1:0] starve_nxt;
  logic             in_req;
  logic             rsp_hit;

  // Data side wins ties until fetch has waited STARVE_MAX data grants.
  always_comb begin
    pick_dmem  = dmem_req_i && !(imem_req_i && (starve_q == STARVE_LIM));
    starve_nxt = '0;
    if (pick_dmem && imem_req_i) begin
      starve_nxt = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IMEM;
      starve_q <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (imem_req_i || dmem_req_i) begin
            state_q  <= ST_REQ;
            starve_q <= starve_nxt;
            if (pick_dmem) begin
              owner_q <= OWN_DMEM;
              addr_q  <= dmem_addr_i;
              wr_q    <= dmem_wr_i;
              wdata_q <= dmem_wdata_i;
              be_q    <= dmem_be_i;
            end else begin
              owner_q <= OWN_IMEM;
              addr_q  <= imem_addr_i;
              wr_q    <= 1'b0;
              wdata_q <= '0;
              be_q    <= BE_FULL;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            state_q <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (mem_rvalid_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Grant and response are steered combinationally to the owner only.
  always_comb begin
    in_req        = (state_q == ST_REQ);
    rsp_hit       = (state_q == ST_RSP) && mem_rvalid_i;

    mem_req_o     = in_req;
    mem_wr_o      = wr_q;
    mem_addr_o    = addr_q;
    mem_wdata_o   = wdata_q;
    mem_be_o      = be_q;

    imem_gnt_o    = in_req && mem_gnt_i && (owner_q == OWN_IMEM);
    dmem_gnt_o    = in_req && mem_gnt_i && (owner_q == OWN_DMEM);
    imem_rvalid_o = rsp_hit && (owner_q == OWN_IMEM);
    dmem_rvalid_o = rsp_hit && (owner_q == OWN_DMEM);
    imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : '0;
    dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Randomized scoreboard bench for yarp_mem_arbiter with a rule-level arbitration model.
module tb_yarp_mem_arbiter;
  import yarp_pkg::*;

  localparam int SMAX = 4;

  logic        clk;
  logic        reset_n;
  logic        imem_req_i;
  logic [31:0] imem_addr_i;
  logic        imem_gnt_o, imem_rvalid_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i;
  logic [31:0] dmem_addr_i;
  logic        dmem_wr_i;
  logic [31:0] dmem_wdata_i;
  logic [3:0]  dmem_be_i;
  logic        dmem_gnt_o, dmem_rvalid_o;
  logic [31:0] dmem_rdata_o;
  logic        mem_req_o, mem_wr_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  yarp_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
    .imem_gnt_o(imem_gnt_o), .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
    .dmem_req_i(dmem_req_i), .dmem_addr_i(dmem_addr_i), .dmem_wr_i(dmem_wr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_be_i(dmem_be_i),
    .dmem_gnt_o(dmem_gnt_o), .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    owner_e      own;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     rv_count = 0;
  txn_t   exp_q[$];
  owner_e rsp_q[$];
  owner_e exp_order[$];

  // Agent state (written only by the stimulus process)
  bit          i_pend, i_cont, i_auto;
  logic [31:0] i_addr;
  bit          d_pend, d_cont, d_auto;
  logic [31:0] d_addr, d_wdata;
  logic        d_wr;
  logic [3:0]  d_be;
  int          m_st, m_wait, g_stall, r_lat;
  bit          m_rand, spur, rd_fixed, stray_once, rv_real;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_zero_outputs(input string nm);
    chk({nm, "_addr"}, mem_addr_o, 32'h0);
    chk({nm, "_wdata"}, mem_wdata_o, 32'h0);
    chk({nm, "_ctrl"}, 32'({mem_req_o, mem_wr_o, mem_be_o, imem_gnt_o, dmem_gnt_o,
                            imem_rvalid_o, dmem_rvalid_o}), 32'h0);
    chk({nm, "_rdata"}, imem_rdata_o | dmem_rdata_o, 32'h0);
  endfunction

  // Monitor / scoreboard
  bit          rst_prev = 1'b0;
  bit          prev_mreq, prev_ireq, prev_dreq, prev_dwr;
  logic [31:0] prev_iaddr, prev_daddr, prev_dwdata;
  logic [3:0]  prev_dbe;
  int          starve;

  initial begin
    txn_t   t;
    owner_e o;
    #2;
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n && rst_prev) begin
        #1;
        chk_zero_outputs("async_reset");
        rst_prev = 1'b0;
      end else begin
        rst_prev = reset_n;
        if (!reset_n) begin
          chk_zero_outputs("in_reset");
          exp_q.delete();
          rsp_q.delete();
          starve    = 0;
          prev_mreq = 1'b0;
        end else begin
          if (mem_req_o && !prev_mreq) begin
            if (!prev_ireq && !prev_dreq) begin
              chk("req_without_requester", 32'(mem_req_o), 32'h0);
            end else begin
              if (prev_dreq && !(prev_ireq && starve == SMAX)) begin
                t = '{OWN_DMEM, prev_daddr, prev_dwr, prev_dwdata, prev_dbe};
              end else begin
                t = '{OWN_IMEM, prev_iaddr, 1'b0, 32'h0, 4'hF};
              end
              if (t.own == OWN_DMEM && prev_ireq) starve = (starve < SMAX) ? starve + 1 : SMAX;
              else starve = 0;
              exp_q.push_back(t);
            end
          end
          if (mem_req_o && exp_q.size() > 0) begin
            t = exp_q[0];
            chk("mem_addr", mem_addr_o, t.addr);
            chk("mem_wdata", mem_wdata_o, t.wdata);
            chk("mem_wr_be", 32'({mem_wr_o, mem_be_o}), 32'({t.wr, t.be}));
            if (mem_gnt_i) begin
              chk("gnt_imem", 32'(imem_gnt_o), 32'(t.own == OWN_IMEM));
              chk("gnt_dmem", 32'(dmem_gnt_o), 32'(t.own == OWN_DMEM));
              if (exp_order.size() > 0) begin
                o = exp_order.pop_front();
                chk("grant_order", 32'(t.own), 32'(o));
              end
              void'(exp_q.pop_front());
              rsp_q.push_back(t.own);
            end else begin
              chk("gnt_while_stalled", 32'({imem_gnt_o, dmem_gnt_o}), 32'h0);
            end
          end else begin
            chk("req_unexpected", 32'(mem_req_o), 32'h0);
            chk("gnt_outside_req", 32'({imem_gnt_o, dmem_gnt_o}), 32'h0);
          end
          if (rv_real) begin
            rv_count++;
            if (rsp_q.size() == 0) begin
              chk("rsp_without_grant", 32'({imem_rvalid_o, dmem_rvalid_o}), 32'h0);
            end else begin
              o = rsp_q.pop_front();
              chk("rvalid_pair", 32'({imem_rvalid_o, dmem_rvalid_o}),
                  (o == OWN_IMEM) ? 32'h2 : 32'h1);
              chk("rdata_owner", (o == OWN_IMEM) ? imem_rdata_o : dmem_rdata_o, mem_rdata_i);
              chk("rdata_other", (o == OWN_IMEM) ? dmem_rdata_o : imem_rdata_o, 32'h0);
            end
          end else begin
            chk("rvalid_spurious", 32'({imem_rvalid_o, dmem_rvalid_o}), 32'h0);
            chk("rdata_spurious", imem_rdata_o | dmem_rdata_o, 32'h0);
          end
          prev_mreq   = mem_req_o;
          prev_ireq   = imem_req_i;
          prev_iaddr  = imem_addr_i;
          prev_dreq   = dmem_req_i;
          prev_daddr  = dmem_addr_i;
          prev_dwr    = dmem_wr_i;
          prev_dwdata = dmem_wdata_i;
          prev_dbe    = dmem_be_i;
        end
      end
    end
  end

  // One clock of requester and memory agents; inputs change 1 time unit after posedge.
  task automatic step();
    logic ig, dg;
    @(negedge clk);
    ig = imem_gnt_o;
    dg = dmem_gnt_o;
    @(posedge clk);
    #1;
    if (i_pend && ig) i_pend = 1'b0;
    if (!i_pend && (i_cont || (i_auto && $urandom_range(0, 2) == 0))) begin
      i_pend = 1'b1;
      i_addr = $urandom & 32'hFFFF_FFFC;
    end
    imem_req_i  = i_pend;
    imem_addr_i = i_pend ? i_addr : $urandom;
    if (d_pend && dg) d_pend = 1'b0;
    if (!d_pend && (d_cont || (d_auto && $urandom_range(0, 2) == 0))) begin
      d_pend  = 1'b1;
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wr    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
      d_be    = 4'($urandom_range(1, 15));
    end
    dmem_req_i   = d_pend;
    dmem_addr_i  = d_pend ? d_addr : $urandom;
    dmem_wr_i    = d_pend ? d_wr : 1'($urandom_range(0, 1));
    dmem_wdata_i = d_pend ? d_wdata : $urandom;
    dmem_be_i    = d_pend ? d_be : 4'($urandom_range(0, 15));

    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    rv_real      = 1'b0;
    mem_rdata_i  = rd_fixed ? 32'hDEAD_BEEF : $urandom;
    if (stray_once) begin
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      stray_once   = 1'b0;
    end else if (m_st == 0) begin
      if (mem_req_o) begin
        if (m_wait == 0) begin
          mem_gnt_i = 1'b1;
          m_st      = 1;
          m_wait    = m_rand ? int'($urandom_range(0, 3)) : r_lat;
        end else begin
          m_wait--;
          if (spur) mem_rvalid_i = 1'($urandom_range(0, 1));
        end
      end else if (spur) begin
        mem_rvalid_i = 1'($urandom_range(0, 1));
        mem_gnt_i    = 1'($urandom_range(0, 1));
      end
    end else begin
      if (m_wait == 0) begin
        mem_rvalid_i = 1'b1;
        rv_real      = 1'b1;
        m_st         = 0;
        m_wait       = m_rand ? int'($urandom_range(0, 3)) : g_stall;
      end else begin
        m_wait--;
        if (spur) mem_gnt_i = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic set_mem(input int stall, input int lat, input bit rnd, input bit sp);
    g_stall = stall;
    r_lat   = lat;
    m_rand  = rnd;
    spur    = sp;
    m_wait  = stall;
  endtask

  task automatic stop_bench(input string nm, input int got, input int req);
    $display("FAIL timeout_%s: got %0d required %0d", nm, got, req);
    $fatal(1, "bench stopped: %s did not complete", nm);
  endtask

  task automatic run_rv(input int n, input int budget, input string nm);
    int tgt = rv_count + n;
    int c   = 0;
    while (rv_count < tgt) begin
      step();
      c++;
      if (c > budget) stop_bench(nm, rv_count, tgt);
    end
    step();
  endtask

  task automatic drain(input string nm);
    int c = 0;
    i_auto = 0; d_auto = 0; i_cont = 0; d_cont = 0;
    while (i_pend || d_pend || m_st != 0 || mem_req_o) begin
      step();
      c++;
      if (c > 300) stop_bench(nm, c, 300);
    end
    repeat (2) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_pend = 0; d_pend = 0; i_cont = 0; d_cont = 0; i_auto = 0; d_auto = 0;
    imem_req_i = 1'b0; dmem_req_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; rv_real = 1'b0;
    m_st = 0; m_wait = g_stall; stray_once = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int c;
    imem_addr_i = '0; dmem_addr_i = '0; dmem_wr_i = 1'b0; dmem_wdata_i = '0;
    dmem_be_i = '0; mem_rdata_i = '0; rd_fixed = 0;
    set_mem(0, 0, 0, 0);
    do_reset();
    repeat (2) step();

    // Fetch alone, zero-wait memory, fixed read data
    rd_fixed = 1;
    i_pend = 1; i_addr = 32'h0000_0100;
    exp_order.push_back(OWN_IMEM);
    run_rv(1, 20, "fetch_alone");
    rd_fixed = 0;

    // Simultaneous requests: store wins, then fetch
    i_pend = 1; i_addr = 32'h0000_0200;
    d_pend = 1; d_addr = 32'h0000_0400; d_wr = 1'b1; d_wdata = 32'h1234_5678; d_be = 4'h3;
    exp_order.push_back(OWN_DMEM);
    exp_order.push_back(OWN_IMEM);
    run_rv(2, 30, "simultaneous");

    // Both held requesting: D,D,D,D,I repeating
    do_reset();
    i_cont = 1; d_cont = 1;
    for (int k = 0; k < 10; k++) exp_order.push_back((k % 5 == 4) ? OWN_IMEM : OWN_DMEM);
    run_rv(10, 60, "starvation");
    drain("starvation_drain");

    // Memory stalls grant 5 cycles, response 3 cycles later
    set_mem(5, 3, 0, 0);
    d_pend = 1; d_addr = 32'h0000_0800; d_wr = 1'b0; d_wdata = 32'h0; d_be = 4'hF;
    exp_order.push_back(OWN_DMEM);
    run_rv(1, 30, "stall");

    // Spurious grant/rvalid with no requesters
    set_mem(0, 0, 0, 1);
    repeat (12) step();

    // Randomized traffic
    set_mem(0, 0, 1, 1);
    i_auto = 1; d_auto = 1;
    run_rv(150, 6000, "random");
    drain("random_drain");

    // Reset while waiting for the response, then a late rvalid
    set_mem(0, 6, 0, 0);
    d_pend = 1; d_addr = 32'h0000_0040; d_wr = 1'b1; d_wdata = 32'hCAFE_F00D; d_be = 4'hC;
    c = 0;
    while (m_st != 1) begin
      step();
      c++;
      if (c > 20) stop_bench("reset_setup", c, 20);
    end
    repeat (2) step();
    #1;
    reset_n = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hA5A5_A5A5;
    i_pend = 0; d_pend = 0; m_st = 0; m_wait = 0;
    imem_req_i = 1'b0; dmem_req_i = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    stray_once = 1;
    repeat (4) step();

    // Recovery after reset
    set_mem(0, 0, 0, 0);
    i_pend = 1; i_addr = 32'h0000_0300;
    exp_order.push_back(OWN_IMEM);
    run_rv(1, 20, "post_reset");
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
